fetch_stage: RTL

Instruction-fetch stage of the RISC-V core, directly upstream of decode. Owns the PC, issues in-order word requests to instruction memory, buffers returned words in a small FIFO, and presents `{pc, instr, opcode}` to decode over a valid/ready handshake. `id_opcode` drives the main controller's 7-bit `Opcode` input. Branch/jump redirects flush buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its consumers.
package fetch_pkg;

    localparam int unsigned FETCH_PC_W = 32;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;

    // Opcode encodings shared with the main controller
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] IMM    = 7'b0010011;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_LSB +: OPCODE_W];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with clear; head is visible combinationally.
module fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, response FIFO, decode handshake.
// Define FETCH_BYPASS_EN to forward a response to id_* in its arrival cycle when the FIFO is empty.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      PC_W     = 32,
    parameter int unsigned      DEPTH    = 2,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_W-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [PC_W-1:0]     id_pc,
    output logic [31:0]         id_instr,
    output logic [6:0]          id_opcode
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 2;

    logic [PC_W-1:0]      pc;
    logic [CW-1:0]        discard;

    logic [PC_W-1:0]      tag_head;
    logic [CW-1:0]        tag_count;
    logic                 tag_full;
    logic                 tag_empty;

    logic [PC_W+31:0]     data_head;
    logic [CW-1:0]        data_count;
    logic                 data_full;
    logic                 data_empty;

    logic [SW-1:0]        in_use;
    logic                 req_fire;
    logic                 rsp_accept;
    logic                 bypass;
    logic                 data_push;
    logic                 data_pop;

    // Credits cover in-flight, to-be-discarded and buffered words, so every response has a slot
    assign in_use         = SW'(tag_count) + SW'(discard) + SW'(data_count);
    assign imem_req_valid = !reset && !redirect_valid && !tag_full && !data_full
                            && (in_use < SW'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_accept     = imem_rsp_valid && (discard == '0) && !redirect_valid && !tag_empty;

`ifdef FETCH_BYPASS_EN
    assign bypass = data_empty && (discard == '0) && imem_rsp_valid;
`else
    assign bypass = 1'b0;
`endif

    assign data_push = rsp_accept && !(bypass && id_ready);
    assign data_pop  = id_ready && !data_empty;

    fetch_fifo #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_accept),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .W     (PC_W + 32),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (data_push),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (data_pop),
        .head      (data_head),
        .count     (data_count),
        .full      (data_full),
        .empty     (data_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~PC_W'(3);
        end else if (req_fire) begin
            pc <= pc + PC_W'(4);
        end
    end

    // On redirect every in-flight response becomes stale; one arriving now is already dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            discard <= '0;
        end else if (redirect_valid) begin
            discard <= discard + tag_count - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (discard != '0)) begin
            discard <= discard - 1'b1;
        end
    end

    always_comb begin
        id_valid = 1'b0;
        id_pc    = '0;
        id_instr = NOP_INSTR;
        if (!data_empty) begin
            id_valid = 1'b1;
            id_pc    = data_head[PC_W+31:32];
            id_instr = data_head[31:0];
        end else if (bypass) begin
            id_valid = 1'b1;
            id_pc    = tag_head;
            id_instr = imem_rsp_data;
        end
    end

    assign id_opcode = opcode_of(id_instr);

endmodule
